// File: rtl/mips_harvard_mem_responder.sv
// Harvard memory responder: combinational fetch/load reads, clocked stores, preload port with auto-increment pointer.
// Define MIPS_MEM_STATS_EN to add saturating accepted-read/write counters.
module mips_harvard_mem_responder #(
  parameter logic [31:0] INSTR_BASE  = 32'hBFC00000,
  parameter int unsigned INSTR_WORDS = 1024,
  parameter logic [31:0] DATA_BASE   = 32'h00000000,
  parameter int unsigned DATA_WORDS  = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_address,
  output logic [31:0] instr_readdata,
  input  logic [31:0] data_address,
  input  logic        data_write,
  input  logic        data_read,
  input  logic [31:0] data_writedata,
  output logic [31:0] data_readdata,
  input  logic        init_mem,
  input  logic        init_load_addr,
  input  logic [31:0] init_mem_addr,
  input  logic [31:0] init_instr,
  output logic [31:0] init_ptr,
  output logic        err_misaligned,
  output logic        err_range
`ifdef MIPS_MEM_STATS_EN
  ,
  output logic [31:0] read_count,
  output logic [31:0] write_count
`endif
);
  localparam int IAW = $clog2(INSTR_WORDS);
  localparam int DAW = $clog2(DATA_WORDS);

  logic [31:0] instr_mem_q [INSTR_WORDS];
  logic [31:0] data_mem_q  [DATA_WORDS];

  logic [31:0] fetch_wi, data_wi, init_wi;
  logic        fetch_ok, data_ok, data_aligned, init_ok;
  logic        data_acc, store_en, load_en, preload_wr, preload_en;

  logic [31:0] init_ptr_q, init_ptr_d;
  logic        err_misaligned_q, err_misaligned_d;
  logic        err_range_q, err_range_d;

  // Unsigned subtraction makes anything below the base wrap to a huge index.
  always_comb begin
    fetch_wi     = (instr_address - INSTR_BASE) >> 2;
    data_wi      = (data_address - DATA_BASE) >> 2;
    init_wi      = (init_ptr_q - INSTR_BASE) >> 2;
    fetch_ok     = fetch_wi < INSTR_WORDS;
    data_ok      = data_wi < DATA_WORDS;
    init_ok      = init_wi < INSTR_WORDS;
    data_aligned = data_address[1:0] == 2'b00;
    data_acc     = (data_read || data_write) && !reset;
    store_en     = data_write && !reset && data_ok && data_aligned;
    load_en      = data_read && !reset && data_ok && data_aligned;
    preload_wr   = init_mem && !init_load_addr;
    preload_en   = preload_wr && init_ok;
  end

  always_comb begin
    instr_readdata = '0;
    data_readdata  = '0;
    if (fetch_ok) begin
      instr_readdata = instr_mem_q[fetch_wi[IAW-1:0]];
    end
    if (data_read && data_ok && data_aligned) begin
      data_readdata = data_mem_q[data_wi[DAW-1:0]];
    end
  end

  always_comb begin
    err_misaligned_d = err_misaligned_q;
    err_range_d      = err_range_q;
    init_ptr_d       = init_ptr_q;
    if (reset) begin
      err_misaligned_d = 1'b0;
      err_range_d      = 1'b0;
      init_ptr_d       = INSTR_BASE;
    end else begin
      if (data_acc && !data_aligned) err_misaligned_d = 1'b1;
      if ((data_acc && !data_ok) || !fetch_ok || (preload_wr && !init_ok)) begin
        err_range_d = 1'b1;
      end
    end
    // Preload runs regardless of reset, so it overrides the pointer reset value.
    if (init_mem) begin
      init_ptr_d = init_load_addr ? init_mem_addr : init_ptr_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    init_ptr_q       <= init_ptr_d;
    err_misaligned_q <= err_misaligned_d;
    err_range_q      <= err_range_d;
  end

  always_ff @(posedge clk) begin
    if (preload_en) begin
      instr_mem_q[init_wi[IAW-1:0]] <= init_instr;
    end
  end

  always_ff @(posedge clk) begin
    if (store_en) begin
      data_mem_q[data_wi[DAW-1:0]] <= data_writedata;
    end
  end

  assign init_ptr       = init_ptr_q;
  assign err_misaligned = err_misaligned_q;
  assign err_range      = err_range_q;

`ifdef MIPS_MEM_STATS_EN
  logic [31:0] read_count_q, read_count_d;
  logic [31:0] write_count_q, write_count_d;

  always_comb begin
    read_count_d  = read_count_q;
    write_count_d = write_count_q;
    if (reset) begin
      read_count_d  = '0;
      write_count_d = '0;
    end else begin
      if (load_en && read_count_q != 32'hFFFFFFFF) read_count_d = read_count_q + 32'd1;
      if (store_en && write_count_q != 32'hFFFFFFFF) write_count_d = write_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    read_count_q  <= read_count_d;
    write_count_q <= write_count_d;
  end

  assign read_count  = read_count_q;
  assign write_count = write_count_q;
`else
  logic unused_load_en;
  assign unused_load_en = load_en;
`endif

endmodule

// File: tb/tb_mips_harvard_mem_responder.sv
// Directed + randomized bench for mips_harvard_mem_responder, checked against a word-map reference model.
module tb_mips_harvard_mem_responder;
  localparam logic [31:0] IB = 32'hBFC00000;
  localparam int unsigned IW = 1024;
  localparam logic [31:0] DB = 32'h00000000;
  localparam int unsigned DW = 1024;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] instr_address, instr_readdata;
  logic [31:0] data_address, data_writedata, data_readdata;
  logic        data_write, data_read;
  logic        init_mem, init_load_addr;
  logic [31:0] init_mem_addr, init_instr, init_ptr;
  logic        err_misaligned, err_range;
`ifdef MIPS_MEM_STATS_EN
  logic [31:0] read_count, write_count;
`endif

  always #5 clk = ~clk;

  mips_harvard_mem_responder dut (
    .clk(clk), .reset(reset),
    .instr_address(instr_address), .instr_readdata(instr_readdata),
    .data_address(data_address), .data_write(data_write), .data_read(data_read),
    .data_writedata(data_writedata), .data_readdata(data_readdata),
    .init_mem(init_mem), .init_load_addr(init_load_addr),
    .init_mem_addr(init_mem_addr), .init_instr(init_instr), .init_ptr(init_ptr),
    .err_misaligned(err_misaligned), .err_range(err_range)
`ifdef MIPS_MEM_STATS_EN
    , .read_count(read_count), .write_count(write_count)
`endif
  );

  // Reference model: sparse word maps plus expected pointer, flags and counters.
  logic [31:0] im [int unsigned];
  logic [31:0] dm [int unsigned];
  logic [31:0] m_ptr, m_rc, m_wc;
  logic        m_mis, m_rng;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic bit in_win(input logic [31:0] a, input logic [31:0] base, input int unsigned words);
    logic [31:0] off;
    off = a - base;
    return off < 32'(4 * words);
  endfunction

  function automatic int unsigned widx(input logic [31:0] a, input logic [31:0] base);
    logic [31:0] off;
    off = a - base;
    return int'(off / 4);
  endfunction

  // One clock: check combinational reads, predict the edge, then check state.
  task automatic step(input string tag);
    bit iok, dok, al, pok;
    logic [31:0] n_ptr;
    logic n_mis, n_rng;
    #2;
    iok = in_win(instr_address, IB, IW);
    dok = in_win(data_address, DB, DW);
    al  = data_address[1:0] == 2'b00;
    pok = in_win(m_ptr, IB, IW);
    if (!iok) chk({tag, "_fetch"}, instr_readdata, 32'h0);
    else if (im.exists(widx(instr_address, IB))) chk({tag, "_fetch"}, instr_readdata, im[widx(instr_address, IB)]);
    if (data_read && dok && al) begin
      if (dm.exists(widx(data_address, DB))) chk({tag, "_load"}, data_readdata, dm[widx(data_address, DB)]);
    end else begin
      chk({tag, "_load"}, data_readdata, 32'h0);
    end
    n_mis = m_mis; n_rng = m_rng; n_ptr = m_ptr;
    if (reset) begin
      n_mis = 0; n_rng = 0; n_ptr = IB; m_rc = 0; m_wc = 0;
    end else begin
      if ((data_read || data_write) && !al) n_mis = 1;
      if ((data_read || data_write) && !dok) n_rng = 1;
      if (!iok) n_rng = 1;
      if (init_mem && !init_load_addr && !pok) n_rng = 1;
      if (data_read && dok && al && m_rc != 32'hFFFFFFFF) m_rc++;
      if (data_write && dok && al && m_wc != 32'hFFFFFFFF) m_wc++;
      if (data_write && dok && al) dm[widx(data_address, DB)] = data_writedata;
    end
    if (init_mem) begin
      if (init_load_addr) n_ptr = init_mem_addr;
      else begin
        if (pok) im[widx(m_ptr, IB)] = init_instr;
        n_ptr = m_ptr + 32'd4;
      end
    end
    @(posedge clk);
    #1;
    m_ptr = n_ptr; m_mis = n_mis; m_rng = n_rng;
    chk({tag, "_ptr"}, init_ptr, m_ptr);
    chk({tag, "_mis"}, 32'(err_misaligned), 32'(m_mis));
    chk({tag, "_rng"}, 32'(err_range), 32'(m_rng));
`ifdef MIPS_MEM_STATS_EN
    chk({tag, "_rc"}, read_count, m_rc);
    chk({tag, "_wc"}, write_count, m_wc);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL timeout n_chk=%0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    m_rc = 0; m_wc = 0; m_mis = 0; m_rng = 0; m_ptr = IB;
    reset = 1; instr_address = IB; data_address = 0; data_write = 0; data_read = 0;
    data_writedata = 0; init_mem = 0; init_load_addr = 0; init_mem_addr = 0; init_instr = 0;
    step("rst0");
    step("rst1");
    chk("rst_ptr", init_ptr, 32'hBFC00000);
    chk("rst_mis", 32'(err_misaligned), 32'h0);
    chk("rst_rng", 32'(err_range), 32'h0);

    // Preload while reset is still high.
    init_mem = 1; init_load_addr = 1; init_mem_addr = 32'hBFC00000;
    step("pl_ld");
    init_load_addr = 0;
    init_instr = 32'h8C020000; step("pl0");
    init_instr = 32'h00641024; step("pl1");
    init_instr = 32'h00000000; step("pl2");
    init_mem = 0;
    chk("t1_ptr", init_ptr, 32'hBFC0000C);
    reset = 0;
    instr_address = IB;       #1 chk("t1_f0", instr_readdata, 32'h8C020000);
    instr_address = IB + 4;   #1 chk("t1_f1", instr_readdata, 32'h00641024);
    instr_address = IB + 8;   #1 chk("t1_f2", instr_readdata, 32'h00000000);
    step("t1");

    for (int i = 0; i < 16; i++) begin
      data_write = 1; data_address = 32'(i * 4); data_writedata = 0;
      step("zero");
    end

    data_address = 4; data_writedata = 32'h22222222; step("t2_st");
    data_write = 0; data_read = 1;
    #1 chk("t2_rd4", data_readdata, 32'h22222222);
    step("t2_ld4");
    data_address = 8;
    #1 chk("t2_rd8", data_readdata, 32'h0);
    step("t2_ld8");

    data_read = 0; data_write = 1; data_address = 32'h10; data_writedata = 32'h11111111;
    step("t3_st");
    data_read = 1; data_writedata = 32'h33333333;
    #1 chk("t3_old", data_readdata, 32'h11111111);
    step("t3_rw");
    data_write = 0;
    #1 chk("t3_new", data_readdata, 32'h33333333);
    step("t3_ld");

    data_read = 0; data_write = 1; data_address = 6; data_writedata = 32'hAAAAAAAA;
    step("t4_st");
    chk("t4_mis", 32'(err_misaligned), 32'h1);
    data_write = 0; data_read = 1; data_address = 4;
    #1 chk("t4_keep", data_readdata, 32'h22222222);
    step("t4_ld");
    chk("t4_sticky", 32'(err_misaligned), 32'h1);
    chk("t4_norng", 32'(err_range), 32'h0);

    data_address = DB + 32'(4 * DW);
    #1 chk("t5_rd", data_readdata, 32'h0);
    step("t5_ld");
    chk("t5_rng", 32'(err_range), 32'h1);

    reset = 1; data_read = 0; data_write = 1; data_address = 4; data_writedata = 32'hDEADBEEF;
    step("t6_rst");
    chk("t6_mis0", 32'(err_misaligned), 32'h0);
    chk("t6_rng0", 32'(err_range), 32'h0);
    step("t6_rst2");
    reset = 0; data_write = 0; data_read = 1;
    #1 chk("t6_keep", data_readdata, 32'h22222222);
    step("t6_ld");
    data_read = 0;

    instr_address = IB + 6;
    #1 chk("trunc_f", instr_readdata, 32'h00641024);
    step("trunc");
    chk("trunc_rng", 32'(err_range), 32'h0);
    instr_address = 32'hBFBFFFFC;
    #1 chk("t5_fetch", instr_readdata, 32'h0);
    step("t5_f");
    chk("t5_frng", 32'(err_range), 32'h1);
    instr_address = IB;

    reset = 1; step("rst3");
    reset = 0; init_mem = 1; init_instr = 32'h24080005;
    #1 chk("pl_old", instr_readdata, 32'h8C020000);
    step("pl_hit");
    init_mem = 0;
    #1 chk("pl_new", instr_readdata, 32'h24080005);
    chk("pl_ptr", init_ptr, 32'hBFC00004);

    init_mem = 1; init_load_addr = 1; init_mem_addr = 32'hFFFFFFFC; step("wr_ld");
    init_load_addr = 0; init_instr = 32'h12345678; step("wr_wr");
    init_mem = 0;
    chk("wrap_ptr", init_ptr, 32'h0);
    chk("wrap_rng", 32'(err_range), 32'h1);

    reset = 1; step("rst4");
    reset = 0; data_read = 1;
    for (int i = 0; i < 15; i++) begin
      data_address = 32'(i % 16) * 4; step("st_ld");
    end
    data_read = 0; data_write = 1;
    data_address = 32'h20; data_writedata = $urandom; step("st_st0");
    data_address = 32'h24; data_writedata = $urandom; step("st_st1");
    data_write = 0;
`ifdef MIPS_MEM_STATS_EN
    chk("t6_rc", read_count, 32'd15);
    chk("t6_wc", write_count, 32'd2);
`endif

    for (int i = 0; i < 300; i++) begin
      reset = $urandom_range(0, 99) < 3;
      data_read = !reset && ($urandom_range(0, 1) == 1);
      data_write = $urandom_range(0, 2) == 0;
      data_writedata = $urandom;
      case ($urandom_range(0, 19))
        0: data_address = 32'h1000 + 32'($urandom_range(0, 63)) * 4;
        1: data_address = 32'($urandom_range(0, 15)) * 4 + 32'($urandom_range(1, 3));
        default: data_address = 32'($urandom_range(0, 15)) * 4;
      endcase
      init_mem = $urandom_range(0, 9) == 0;
      init_load_addr = init_mem && ($urandom_range(0, 3) == 0);
      init_mem_addr = IB + 32'($urandom_range(0, 7)) * 4;
      init_instr = $urandom;
      case ($urandom_range(0, 19))
        0: instr_address = 32'hBFBFFFF0;
        1: instr_address = IB + 32'(4 * IW);
        default: instr_address = IB + 32'($urandom_range(0, 7)) * 4;
      endcase
      step("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/mips_harvard_mem_responder.md
Name: mips_harvard_mem_responder

Overview:
Memory-side responder for the Harvard CPU memory interfaces. It serves the instruction fetch port and the data load/store port of mips_cpu_harvard, and adds a preload port for program images. It contains separate word-addressed instruction and data arrays, sticky access-error flags, and an auto-incrementing preload pointer. It sits beside the CPU in testbenches and in the simulation top level.

Parameters:
INSTR_BASE, 32'hBFC00000, byte address of instruction word 0 (reset vector)
INSTR_WORDS, 1024, instruction array depth in 32-bit words (power of 2)
DATA_BASE, 32'h00000000, byte address of data word 0
DATA_WORDS, 1024, data array depth in 32-bit words (power of 2)

Ports:
clk  in  1  system clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
instr_address  in  32  CPU fetch byte address
instr_readdata  out  32  combinational fetch data
data_address  in  32  CPU load/store byte address
data_write  in  1  store strobe; single-cycle write at the clk edge
data_read  in  1  load strobe
data_writedata  in  32  store data
data_readdata  out  32  combinational load data
init_mem  in  1  preload strobe, one word per cycle
init_load_addr  in  1  when high with init_mem, load the pointer from init_mem_addr instead of writing
init_mem_addr  in  32  preload byte address; word index is relative to INSTR_BASE
init_instr  in  32  preload word
init_ptr  out  32  current preload byte address
err_misaligned  out  1  sticky: data access with data_address[1:0] != 0
err_range  out  1  sticky: data or fetch access outside its window

Behaviour:
- Address decode:
  - Instruction index = (addr - INSTR_BASE) >> 2. Data index = (addr - DATA_BASE) >> 2.
  - An address is in range when it is 0 <= addr - base < 4*WORDS. The subtraction is unsigned 32-bit, so any wrap below the base counts as out of range.
- instr_readdata:
  - Combinational, 0 latency.
  - Returns the array word when in range; otherwise 32'h00000000 and sets err_range at the next edge.
  - An instr_address with low bits != 0 is word-truncated and raises no error.
- data_readdata:
  - Combinational when data_read = 1 and the address is in range and aligned.
  - Returns 32'h00000000 when data_read = 0, out of range, or misaligned.
- Store:
  - When data_write = 1, the address is in range and aligned, the word is written at the rising edge.
  - With data_read and data_write in the same cycle, readdata shows the old contents; the new value is visible from the next cycle.
  - Misaligned or out-of-range stores are dropped and set the corresponding sticky flag.
- Preload:
  - init_mem with init_load_addr = 1 sets init_ptr <= init_mem_addr; no write.
  - init_mem with init_load_addr = 0 writes init_instr at init_ptr, then init_ptr <= init_ptr + 4.
  - A write from an out-of-range pointer is dropped and sets err_range; the pointer still increments and wraps mod 2^32.
  - Preload is accepted whether or not reset is high.
  - If a fetch hits the word being preloaded in the same cycle, the fetch returns the old word.
- Reset:
  - err_misaligned = 0, err_range = 0, init_ptr = INSTR_BASE.
  - Array contents are not cleared by reset.
  - Data-port strobes are ignored while reset = 1: no writes and no error setting. Preload still proceeds.
  - Asserting reset mid-program stops stores from that edge onward.
- Flags stay set until reset.

Optional Feature:
MIPS_MEM_STATS_EN:
- When defined, adds outputs read_count[31:0] and write_count[31:0].
- The counters increment on each accepted (in-range, aligned, not-in-reset) data_read cycle and data_write cycle respectively, and saturate at 32'hFFFFFFFF. Both clear on reset.
- Without the macro, these ports and counters do not exist.

Test Plan:
1. Preload: init_load_addr with addr BFC00000, then 3 init_mem words 8C020000 / 00641024 / 00000000 -> init_ptr = BFC0000C; fetches at BFC00000, BFC00004 and BFC00008 return the words in order.
2. Store/load: write 22222222 at 0x4, then the next cycle read 0x4 -> data_readdata = 22222222; a read at 0x8 (never written, array pre-zeroed by the bench) -> 0.
3. Simultaneous read and write at 0x10: old 11111111, new 33333333 -> same cycle readdata = 11111111; next cycle = 33333333.
4. Misaligned store to 0x6 -> store dropped; word at 0x4 still 22222222; err_misaligned = 1 until reset; reset -> 0.
5. Out of range: read at DATA_BASE + 4*DATA_WORDS -> readdata = 0 and err_range = 1; fetch at BFBFFFFC -> 0 and err_range set.
6. Reset gating: data_write asserted with reset = 1 -> memory unchanged. With MIPS_MEM_STATS_EN, 15 loads and 2 stores after reset -> read_count = 15, write_count = 2.
